// File: rtl/trace_readout_controller.sv
// Read-side sequencer for the circular trace buffer: snapshots the write pointer,
// walks the buffer oldest-to-newest and aligns rvalid/rlast with the RAM read latency.
module trace_readout_controller #(
    parameter int ADDR_WIDTH  = 4,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  wrapped,
    input  logic                  read_enable,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ram_re,
    output logic                  rvalid,
    output logic                  rlast,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            fsm_state
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_COUNT   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

    // Handshake: one beat is issued per cycle in which ram_re is high; ram_re
    // is READ & read_enable, and each beat emerges RAM_LATENCY cycles later as
    // rvalid (with rlast on the final beat). There is no back-pressure on rvalid.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH:0]    remaining;
    logic [ADDR_WIDTH:0]    snap_count;
    logic                   empty_done;
    logic                   last_beat;
    logic                   accept_start;
    logic [RAM_LATENCY-1:0] valid_pipe;
    logic [RAM_LATENCY-1:0] last_pipe;

    assign snap_count   = wrapped ? DEPTH_COUNT : {1'b0, waddr};
    assign accept_start = (state == IDLE) && start;
    assign ram_re       = (state == READ) && read_enable;
    assign last_beat    = ram_re && (remaining == ONE_COUNT);

    assign rvalid    = valid_pipe[RAM_LATENCY-1];
    assign rlast     = last_pipe[RAM_LATENCY-1];
    assign busy      = (state != IDLE);
    assign done      = empty_done || ((state == DRAIN) && rlast);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && (snap_count != '0)) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The tagged last beat leaving the pipe means nothing else is in flight.
                if (rlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raddr      <= '0;
            remaining  <= '0;
            empty_done <= 1'b0;
        end else begin
            empty_done <= accept_start && (snap_count == '0);
            if (accept_start) begin
                // Oldest sample sits at the write pointer once the buffer has wrapped.
                raddr     <= wrapped ? waddr : '0;
                remaining <= snap_count;
            end else if (ram_re) begin
                raddr     <= raddr + ONE_ADDR;
                remaining <= remaining - ONE_COUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_pipe <= '0;
            last_pipe  <= '0;
        end else begin
            for (int i = RAM_LATENCY - 1; i > 0; i--) begin
                valid_pipe[i] <= valid_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
            end
            valid_pipe[0] <= ram_re;
            last_pipe[0]  <= last_beat;
        end
    end

endmodule

// File: tb/tb_trace_readout_controller.sv
// Directed bench for trace_readout_controller: latency-1 and latency-3 instances
// share clock, reset and data inputs; each has its own start strobe.
module tb_trace_readout_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1;
    logic       start3;
    logic [3:0] waddr;
    logic       wrapped;
    logic       read_enable;

    logic [3:0] raddr1, raddr3;
    logic       ram_re1, ram_re3;
    logic       rvalid1, rvalid3;
    logic       rlast1, rlast3;
    logic       busy1, busy3;
    logic       done1, done3;
    logic [1:0] state1, state3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trace_readout_controller #(.ADDR_WIDTH(4), .RAM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .waddr(waddr), .wrapped(wrapped),
        .read_enable(read_enable), .raddr(raddr1), .ram_re(ram_re1), .rvalid(rvalid1),
        .rlast(rlast1), .busy(busy1), .done(done1), .fsm_state(state1)
    );

    trace_readout_controller #(.ADDR_WIDTH(4), .RAM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .waddr(waddr), .wrapped(wrapped),
        .read_enable(read_enable), .raddr(raddr3), .ram_re(ram_re3), .rvalid(rvalid3),
        .rlast(rlast3), .busy(busy3), .done(done3), .fsm_state(state3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare one cycle of outputs; called just after the negedge where inputs were set.
    task automatic check_cycle(input int sel, input string tag, input logic re,
                               input logic [3:0] addr, input logic v, input logic l,
                               input logic d, input logic b);
        #1;
        if (sel == 3) begin
            chk({tag, "_re"},    32'(ram_re3), 32'(re));
            chk({tag, "_addr"},  32'(raddr3),  32'(addr));
            chk({tag, "_valid"}, 32'(rvalid3), 32'(v));
            chk({tag, "_last"},  32'(rlast3),  32'(l));
            chk({tag, "_done"},  32'(done3),   32'(d));
            chk({tag, "_busy"},  32'(busy3),   32'(b));
        end else begin
            chk({tag, "_re"},    32'(ram_re1), 32'(re));
            chk({tag, "_addr"},  32'(raddr1),  32'(addr));
            chk({tag, "_valid"}, 32'(rvalid1), 32'(v));
            chk({tag, "_last"},  32'(rlast1),  32'(l));
            chk({tag, "_done"},  32'(done1),   32'(d));
            chk({tag, "_busy"},  32'(busy1),   32'(b));
        end
    endtask

    // Pulse start for one edge, then scramble the snapshot inputs; returns in cycle N+1.
    task automatic pulse_start(input int sel, input logic wr, input logic [3:0] a);
        @(negedge clk);
        waddr   = a;
        wrapped = wr;
        if (sel == 3) start3 = 1'b1;
        else          start1 = 1'b1;
        @(negedge clk);
        start1  = 1'b0;
        start3  = 1'b0;
        waddr   = ~a;
        wrapped = ~wr;
    endtask

    // Uninterrupted readout with read_enable high: beats 0..count-1 then drain.
    task automatic check_readout(input int sel, input string tag, input int first,
                                 input int count, input int lat);
        logic [3:0] exp_addr;
        for (int i = 0; i <= count + lat; i++) begin
            exp_addr = (i < count) ? 4'((first + i) % 16) : 4'((first + count) % 16);
            check_cycle(sel, $sformatf("%s_c%0d", tag, i), i < count, exp_addr,
                        (i >= lat) && (i < count + lat), i == count + lat - 1,
                        i == count + lat - 1, i < count + lat);
            @(negedge clk);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start1      = 1'b0;
        start3      = 1'b0;
        waddr       = 4'd0;
        wrapped     = 1'b0;
        read_enable = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check_cycle(1, "rst1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cycle(3, "rst3", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_state", 32'(state1), 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        read_enable = 1'b1;

        // Wrapped readout: 5..15, 0..4
        pulse_start(1, 1'b1, 4'd5);
        check_readout(1, "wrap", 5, 16, 1);

        // Partial buffer: 0, 1, 2
        pulse_start(1, 1'b0, 4'd3);
        check_readout(1, "part", 0, 3, 1);

        // Empty buffer: done only, no activity
        pulse_start(1, 1'b0, 4'd0);
        check_cycle(1, "empty_c0", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("empty_state", 32'(state1), 32'd0);
        @(negedge clk);
        check_cycle(1, "empty_c1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stall pattern 1,0,0,1,1 with an ignored start mid-readout
        pulse_start(1, 1'b1, 4'd14);
        check_cycle(1, "stall_c0", 1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        read_enable = 1'b0;
        check_cycle(1, "stall_c1", 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start1  = 1'b1;
        waddr   = 4'd3;
        wrapped = 1'b0;
        check_cycle(1, "stall_c2", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start1      = 1'b0;
        read_enable = 1'b1;
        check_cycle(1, "stall_c3", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_cycle(1, "stall_c4", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int j = 3; j < 16; j++) begin
            @(negedge clk);
            check_cycle(1, $sformatf("stall_b%0d", j), 1'b1, 4'((14 + j) % 16),
                        1'b1, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        check_cycle(1, "stall_end", 1'b0, 4'd14, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check_cycle(1, "stall_idle", 1'b0, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0);

        // Latency 3: done 19 cycles into the readout
        pulse_start(3, 1'b1, 4'd0);
        check_readout(3, "lat3", 0, 16, 3);

        // Reset during beat 7 of 16
        pulse_start(1, 1'b1, 4'd0);
        for (int i = 0; i < 7; i++) begin
            check_cycle(1, $sformatf("mid_c%0d", i), 1'b1, 4'(i), i > 0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
        end
        check_cycle(1, "mid_c7", 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_cycle(1, "mid_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_state", 32'(state1), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_cycle(1, $sformatf("post_rst_c%0d", i), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Fresh readout after reset
        pulse_start(1, 1'b1, 4'd9);
        check_readout(1, "again", 9, 16, 1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
